// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle between the message sources and the shared UART transmitter.
// The arbiter takes the slave modport. The sources and the UART engine side take master.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_ready;

    modport master (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_valid, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one UART byte transmitter between N_REQ sources.
// Defining UART_ARB_TIMEOUT_EN builds a watchdog that revokes a grant from a stalled owner.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus,
    output logic [N_REQ-1:0] grant,
    output logic             timeout_pulse
);
    localparam int PW = $clog2(N_REQ);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] last_ptr_q, last_ptr_d;
    logic [PW-1:0] win, cand;
    logic          any_req, own_valid, own_last, xfer, stall_hit;

    // Search from the requester after last_ptr, wrapping around, and stop at the first valid one.
    always_comb begin
        win     = last_ptr_q;
        cand    = '0;
        any_req = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = PW'((int'(last_ptr_q) + i) % N_REQ);
            if (!any_req && bus.req_valid[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end

    always_comb begin
        grant         = '0;
        bus.req_ready = '0;
        bus.tx_data   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (state_q == BUSY && owner_q == PW'(i)) begin
                grant[i]         = 1'b1;
                bus.req_ready[i] = bus.tx_ready;
                bus.tx_data      = bus.req_data[8*i +: 8];
            end
        end
    end

    assign own_valid    = |(grant & bus.req_valid);
    assign own_last     = |(grant & bus.req_last);
    assign xfer         = own_valid && bus.tx_ready;
    assign bus.tx_valid = own_valid;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic        to_q;

    assign stall_hit     = (state_q == BUSY) && (stall_q == 16'(TIMEOUT_CYCLES));
    assign timeout_pulse = to_q;

    // Only an absent owner byte counts as a stall. UART backpressure never counts.
    always_comb begin
        stall_d = '0;
        if (state_q == BUSY && !stall_hit && !own_valid) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            to_q    <= 1'b0;
        end else begin
            stall_q <= stall_d;
            to_q    <= stall_hit;
        end
    end
`else
    assign stall_hit     = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_ptr_d = last_ptr_q;
        case (state_q)
            IDLE: if (any_req) begin
                state_d    = BUSY;
                owner_d    = win;
                last_ptr_d = win;
            end
            BUSY: if (stall_hit || (xfer && own_last)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_ptr_q <= PW'(N_REQ - 1);
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_ptr_q <= last_ptr_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter. Expected bytes and owners are queued as messages are issued.
// The timeout scenario is compiled only with UART_ARB_TIMEOUT_EN defined.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] grant;
    logic         timeout_pulse;

    uart_tx_arbiter_if #(.N_REQ(N)) bus();

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .grant        (grant),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]   data;
        logic [N-1:0] gnt;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] src_q[N][$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic put(input int r, input logic [7:0] d, input bit last, input bit expect_out = 1'b1);
        src_q[r].push_back({last, d});
        if (expect_out) sb.push_back('{data: d, gnt: N'(1 << r)});
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && sb.size() > 0; k++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Requester models: a byte leaves its queue once seen accepted, and reset drops the queues.
    initial begin
        logic [N-1:0] acc;
        bit           rst_s;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            acc   = bus.req_valid & bus.req_ready;
            rst_s = reset;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (rst_s) src_q[i].delete();
                else if (acc[i]) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_data[8*i +: 8] = src_q[i][0][7:0];
                    bus.req_last[i]        = src_q[i][0][8];
                end else begin
                    bus.req_valid[i]       = 1'b0;
                    bus.req_data[8*i +: 8] = 8'h00;
                    bus.req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Monitor: every byte on the line must match the next scoreboard entry and its owner.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && bus.tx_valid && bus.tx_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_byte", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("tx_data", 32'(bus.tx_data), 32'(e.data));
                chk("grant", 32'(grant), 32'(e.gnt));
                chk("req_ready", 32'(bus.req_ready), 32'(e.gnt));
`ifndef UART_ARB_TIMEOUT_EN
                chk("pulse_tied", 32'(timeout_pulse), 32'd0);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_pulse", 32'(timeout_pulse), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Single message from requester 0.
        @(negedge clk); #1;
        put(0, 8'h48, 1'b0); put(0, 8'h69, 1'b0); put(0, 8'h0A, 1'b1);
        @(negedge clk);
        chk("t1_lat0_grant", 32'(grant), 32'd0);
        chk("t1_lat0_txv", 32'(bus.tx_valid), 32'd0);
        @(negedge clk);
        chk("t1_lat1_grant", 32'(grant), 32'b0001);
        repeat (3) @(negedge clk);
        chk("t1_end_grant", 32'(grant), 32'd0);
        wait_drain();

        // Requesters 1 and 2 request together, and 1 wins from reset priority.
        do_reset();
        @(negedge clk); #1;
        put(1, 8'h11, 1'b0); put(1, 8'h12, 1'b1);
        put(2, 8'h21, 1'b0); put(2, 8'h22, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t2_first", 32'(grant), 32'b0010);
        chk("t2_hold0", 32'(bus.req_ready[2]), 32'd0);
        @(negedge clk);
        chk("t2_hold1", 32'(bus.req_ready[2]), 32'd0);
        @(negedge clk);
        chk("t2_gap", 32'(grant), 32'd0);
        @(negedge clk);
        chk("t2_second", 32'(grant), 32'b0100);
        wait_drain();

        // All four requesters stream 2-byte messages, and service rotates 0,1,2,3,0,1,2,3.
        do_reset();
        @(negedge clk); #1;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < N; i++) begin
                put(i, 8'(m * 64 + i * 16), 1'b0);
                put(i, 8'(m * 64 + i * 16 + 1), 1'b1);
            end
        wait_drain();

        // UART backpressure mid-message: the byte holds and the owner keeps the grant.
        do_reset();
        @(negedge clk); #1;
        put(0, 8'hA0, 1'b0); put(0, 8'hA1, 1'b0); put(0, 8'hA2, 1'b0); put(0, 8'hA3, 1'b1);
        put(1, 8'hB0, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 bus.tx_ready = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("bp_data", 32'(bus.tx_data), 32'hA2);
            chk("bp_valid", 32'(bus.tx_valid), 32'd1);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_grant", 32'(grant), 32'b0001);
            chk("bp_pulse", 32'(timeout_pulse), 32'd0);
        end
        @(posedge clk); #1 bus.tx_ready = 1'b1;
        wait_drain();

`ifdef UART_ARB_TIMEOUT_EN
        // Owner 0 goes silent after one byte. The watchdog revokes the grant and requester 2 follows.
        do_reset();
        @(negedge clk); #1;
        put(0, 8'hC0, 1'b0);
        put(2, 8'hD0, 1'b0); put(2, 8'hD1, 1'b1);
        repeat (2) @(negedge clk);
        begin
            int k;
            for (k = 1; k <= 30; k++) begin
                @(negedge clk);
                if (timeout_pulse) break;
            end
            // TO stalled cycles build the count, one more cycle sits at the limit, and the strobe follows.
            chk("to_latency", 32'(k), 32'(TO + 2));
            chk("to_grant_clear", 32'(grant), 32'd0);
            @(negedge clk);
            chk("to_pulse_width", 32'(timeout_pulse), 32'd0);
            chk("to_next_grant", 32'(grant), 32'b0100);
        end
        wait_drain();
`endif

        // Reset lands during byte 2 of 4. The message is dropped and priority returns to requester 0.
        do_reset();
        @(negedge clk); #1;
        put(0, 8'hE0, 1'b0);
        put(0, 8'hE1, 1'b0, 1'b0); put(0, 8'hE2, 1'b0, 1'b0); put(0, 8'hE3, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mr_grant", 32'(grant), 32'd0);
        chk("mr_tx_valid", 32'(bus.tx_valid), 32'd0);
        #1;
        put(0, 8'h60, 1'b1);
        put(3, 8'h70, 1'b1);
        repeat (2) @(negedge clk);
        chk("mr_prio", 32'(grant), 32'b0001);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
